// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative HI/LO multiply/divide unit. A multiply or divide is accepted
//   in IDLE, runs WIDTH shift-add / restoring-divide iterations on operand
//   magnitudes in CALC, then applies the sign correction and writes HI/LO
//   in FIX. Total latency is WIDTH+1 clock edges regardless of operands.
//   MTHI/MTLO write HI/LO directly in a single edge.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        request one operation (sampled on a rising edge)
//   op_i           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   src_a_i        first operand / dividend / MTHI-MTLO data
//   src_b_i        second operand / divisor
//   busy_o         multiply or divide in progress
//   done_o         one-cycle pulse when HI/LO receive a mult/div result
//   div_by_zero_o  last completed divide had a zero divisor
//   hi_o, lo_o     HI and LO registers
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CALC = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // acc: running product upper half (multiply) or partial remainder (divide)
    logic [WIDTH:0]   acc_q, acc_d;
    // x: multiplier being shifted out (multiply) or dividend/quotient (divide)
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic               is_signed;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Magnitude of a possibly-signed operand. The most negative value maps
    // to itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign is_signed = ~op_i[0];

    assign mul_sum   = acc_q + (x_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
    // Extra top bit acts as the borrow of the trial subtraction.
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};

    assign prod_mag = {acc_q[WIDTH-1:0], x_q};
    assign prod     = neg_res_q ? -prod_mag : prod_mag;
    // A zero divisor leaves the remainder equal to |dividend|, so the normal
    // remainder sign fix returns the dividend; only LO needs overriding.
    assign quo      = b_zero_q ? '1 : (neg_res_q ? -x_q : x_q);
    assign rem      = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        x_d       = x_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (!op_i[2]) begin
                        state_d   = S_CALC;
                        cnt_d     = '0;
                        acc_d     = '0;
                        x_d       = magnitude(src_a_i, is_signed);
                        b_d       = magnitude(src_b_i, is_signed);
                        is_div_d  = op_i[1];
                        neg_res_d = is_signed & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                        neg_rem_d = is_signed & src_a_i[WIDTH-1];
                        b_zero_d  = (src_b_i == '0);
                    end else if (op_i == OP_MTHI) begin
                        hi_d = src_a_i;
                    end else if (op_i == OP_MTLO) begin
                        lo_d = src_a_i;
                    end
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    if (!div_diff[WIDTH+1]) begin
                        acc_d = div_diff[WIDTH:0];
                        x_d   = {x_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift;
                        x_d   = {x_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {1'b0, mul_sum[WIDTH:1]};
                    x_d   = {mul_sum[0], x_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                dbz_d   = is_div_q & b_zero_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            x_q       <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand, HI and LO data width.
REQ-002 Clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-003 Rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Start  input  1  SHALL request one operation, sampled on a rising edge.
REQ-005 Op  input  3  SHALL select the operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-006 SrcA  input  WIDTH  SHALL carry the first operand (register-file RD1; dividend; MTHI/MTLO data).
REQ-007 SrcB  input  WIDTH  SHALL carry the second operand (register-file RD2; divisor).
REQ-008 Busy  output  1  SHALL be high while a multiply or divide is in progress.
REQ-009 Done  output  1  SHALL be a one-cycle pulse when HI/LO receive a multiply/divide result.
REQ-010 DivByZero  output  1  SHALL flag that the last completed divide had SrcB = 0.
REQ-011 HI  output  WIDTH  SHALL be the HI register (product upper half / remainder).
REQ-012 LO  output  WIDTH  SHALL be the LO register (product lower half / quotient).

Function
REQ-013 The FSM SHALL have states IDLE, CALC and FIX.
REQ-014 In IDLE, Start=1 with Op in {000..011} at edge N SHALL capture SrcA, SrcB and Op, then enter CALC with Busy=1 after edge N.
REQ-015 Later changes on SrcA, SrcB and Op SHALL NOT affect an accepted operation.
REQ-016 CALC SHALL run exactly WIDTH iterations, one per edge (N+1..N+WIDTH), as a shift-add multiply or restoring divide on operand magnitudes.
REQ-017 FIX SHALL last one cycle; at edge N+WIDTH+1 it SHALL apply the sign correction, write HI/LO, clear Busy, set Done=1 for one cycle and return to IDLE.
REQ-018 Result latency SHALL be WIDTH+1 edges after acceptance (33 for WIDTH=32), independent of operand values.
REQ-019 MULT/MULTU SHALL produce the full 2*WIDTH-bit signed or unsigned product, with HI = upper half and LO = lower half.
REQ-020 DIV/DIVU SHALL set LO = quotient and HI = remainder; the signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-021 Signed DIV of most-negative by -1 SHALL yield LO = most-negative value and HI = 0, with no flag.
REQ-022 Divide with SrcB = 0 SHALL still take full latency and set HI = dividend, LO = all ones, DivByZero = 1.
REQ-023 DivByZero SHALL update only at the FIX edge of a divide, and SHALL be cleared at the FIX edge of any other divide or multiply.
REQ-024 MTHI/MTLO with Start=1 in IDLE SHALL write SrcA to HI/LO at that same edge, with no Busy and no Done.
REQ-025 Start SHALL be ignored (no state change) while Busy=1 and for reserved Op codes.
REQ-026 Start in the Done cycle SHALL be accepted normally, giving back-to-back operations.
REQ-027 HI/LO SHALL hold their value between writes.
REQ-028 Busy and Done SHALL never be high in the same cycle.

Reset
REQ-029 Rst=0 SHALL immediately force IDLE and set Busy=0, Done=0, DivByZero=0, HI=0, LO=0 and all internal operand/accumulator registers to 0.
REQ-030 Reset during CALC or FIX SHALL abort the operation with no Done pulse and no HI/LO update.
REQ-031 The first Start SHALL be accepted at the first rising edge after Rst is deasserted.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Busy for 33 edges, Done pulses once, HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 DIVU 100 / 7 -> LO=14, HI=2, DivByZero=0; then DIVU 5 / 0 -> HI=5, LO=0xFFFFFFFF, DivByZero=1.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, DivByZero=0.
REQ-036 MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> HI/LO updated on their respective edges, Busy=0, Done never asserted.
REQ-037 Start MULTU, re-Start with different operands 5 cycles later, assert Rst=0 at cycle 10 of a new operation -> second Start ignored (first result correct); on reset, outputs go to 0 at once and no Done follows.
